// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencing, lock qualification, retry and downstream reset release
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 16
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic       lock_lost,
    output logic [3:0] retry_cnt
);

    typedef enum logic [2:0] {
        ST_RESET_PLL,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         retry_cnt_q, retry_cnt_d;
    logic               lock_lost_q, lock_lost_d;
    logic [1:0]         sync_q, sync_d;
    logic               pll_rst_q, pll_rst_d;
    logic               sys_rst_n_q, sys_rst_n_d;
    logic               ready_q, ready_d;
    logic               fail_q, fail_d;
    logic               locked_s;

    // Two-flop synchroniser: pll_locked is asynchronous to refclk.
    assign locked_s = sync_q[1];

    always_comb begin
        sync_d      = {sync_q[0], pll_locked};
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_cnt_d = retry_cnt_q;
        lock_lost_d = lock_lost_q;

        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_cnt_q >= RETRY_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d     = ST_RESET_PLL;
                        retry_cnt_d = retry_cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STABLE: begin
                // Any dropout restarts qualification; the timeout budget restarts too.
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // Lock loss has priority over a coincident software request.
                if (!locked_s) begin
                    state_d     = ST_RESET_PLL;
                    cnt_d       = '0;
                    retry_cnt_d = '0;
                    lock_lost_d = 1'b1;
                end else if (relock_req) begin
                    state_d     = ST_RESET_PLL;
                    cnt_d       = '0;
                    retry_cnt_d = '0;
                    lock_lost_d = 1'b0;
                end
            end
            ST_FAIL: begin
                if (relock_req) begin
                    state_d     = ST_RESET_PLL;
                    cnt_d       = '0;
                    retry_cnt_d = '0;
                    lock_lost_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_RESET_PLL;
                cnt_d   = '0;
            end
        endcase

        pll_rst_d   = (state_d == ST_RESET_PLL);
        sys_rst_n_d = (state_d == ST_RUN);
        ready_d     = (state_d == ST_RUN);
        fail_d      = (state_d == ST_FAIL);
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q     <= ST_RESET_PLL;
            cnt_q       <= '0;
            retry_cnt_q <= '0;
            lock_lost_q <= 1'b0;
            sync_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_cnt_q <= retry_cnt_d;
            lock_lost_q <= lock_lost_d;
            sync_q      <= sync_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign lock_lost = lock_lost_q;
    assign retry_cnt = retry_cnt_q;

endmodule
